// File: rtl/shiftreg_load_sched_if.sv
// Request/serial bundle between the two config sources and the
// shift-register load scheduler.
interface shiftreg_load_sched_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
);
    logic                  DYN_REQ;
    logic [SIZESRDYN-1:0]  DYN_DATA;
    logic                  STAT_REQ;
    logic [SIZESRSTAT-1:0] STAT_DATA;
    logic                  ABORT;
    logic                  SEL;
    logic                  MOSI;
    logic                  CLK_EN;
    logic                  LOAD;
    logic                  DYN_ACK;
    logic                  STAT_ACK;
    logic                  BUSY;
    logic                  ABORTED;

    modport master (
        output DYN_REQ, DYN_DATA, STAT_REQ, STAT_DATA, ABORT,
        input  SEL, MOSI, CLK_EN, LOAD,
        input  DYN_ACK, STAT_ACK, BUSY, ABORTED
    );

    modport slave (
        input  DYN_REQ, DYN_DATA, STAT_REQ, STAT_DATA, ABORT,
        output SEL, MOSI, CLK_EN, LOAD,
        output DYN_ACK, STAT_ACK, BUSY, ABORTED
    );
endinterface

// File: rtl/shiftreg_load_sched.sv
// Round-robin scheduler serialising static/dynamic config words
// MSB-first onto the shared chain pins, with LOAD strobe and guard gap.
module shiftreg_load_sched #(
    parameter int SIZESRSTAT   = 88,
    parameter int SIZESRDYN    = 16,
    parameter int N_CYCLES_GAP = 30
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    shiftreg_load_sched_if.slave bus
);
    localparam int CW = $clog2(SIZESRSTAT);
    localparam int GW = (N_CYCLES_GAP > 1) ? $clog2(N_CYCLES_GAP) : 1;
    localparam int PADW = SIZESRSTAT - SIZESRDYN;

    localparam logic [CW-1:0] LAST_STAT = CW'(SIZESRSTAT - 1);
    localparam logic [CW-1:0] LAST_DYN  = CW'(SIZESRDYN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(N_CYCLES_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [SIZESRSTAT-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic                  gnt_dyn_q, gnt_dyn_d;
    logic                  last_dyn_q, last_dyn_d;
    logic                  aborted_q, aborted_d;
    logic                  sel_q, sel_d;
    logic                  mosi_q, mosi_d;
    logic                  clk_en_q, clk_en_d;
    logic                  load_q, load_d;
    logic                  dyn_ack_q, dyn_ack_d;
    logic                  stat_ack_q, stat_ack_d;
    logic                  busy_q, busy_d;

    logic pick_dyn;
    logic enter_gap;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        gcnt_d     = gcnt_q;
        gnt_dyn_d  = gnt_dyn_q;
        last_dyn_d = last_dyn_q;
        aborted_d  = aborted_q;
        dyn_ack_d  = 1'b0;
        stat_ack_d = 1'b0;
        mosi_d     = 1'b0;
        clk_en_d   = 1'b0;
        pick_dyn   = 1'b0;
        enter_gap  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.DYN_REQ || bus.STAT_REQ) begin
                    // A tie goes to whichever source did not win last time.
                    unique case (1'b1)
                        !bus.STAT_REQ: pick_dyn = 1'b1;
                        !bus.DYN_REQ:  pick_dyn = 1'b0;
                        default:       pick_dyn = !last_dyn_q;
                    endcase
                    state_d    = S_SETUP;
                    gnt_dyn_d  = pick_dyn;
                    last_dyn_d = pick_dyn;
                    dyn_ack_d  = pick_dyn;
                    stat_ack_d = !pick_dyn;
                    cnt_d      = pick_dyn ? LAST_DYN : LAST_STAT;
                    shreg_d    = pick_dyn ?
                                 {bus.DYN_DATA, {PADW{1'b0}}} :
                                 bus.STAT_DATA;
                end
            end
            S_SETUP: begin
                if (bus.ABORT) begin
                    enter_gap = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.ABORT) begin
                    enter_gap = 1'b1;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = S_LATCH;
                    aborted_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LATCH: begin
                enter_gap = 1'b1;
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_gap) begin
            state_d = (N_CYCLES_GAP == 0) ? S_IDLE : S_GAP;
            gcnt_d  = GAP_LAST;
        end

        // Outputs are decoded from the next state so they register in step.
        if (state_d == S_SHIFT) begin
            clk_en_d = 1'b1;
            mosi_d   = shreg_q[SIZESRSTAT-1];
            shreg_d  = {shreg_q[SIZESRSTAT-2:0], 1'b0};
        end

        sel_d  = 1'b1;
        if (state_d == S_SETUP || state_d == S_SHIFT ||
            state_d == S_LATCH) begin
            sel_d = !gnt_dyn_d;
        end
        load_d = (state_d == S_LATCH);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            gnt_dyn_q  <= 1'b0;
            last_dyn_q <= 1'b0;
            aborted_q  <= 1'b0;
            sel_q      <= 1'b1;
            mosi_q     <= 1'b0;
            clk_en_q   <= 1'b0;
            load_q     <= 1'b0;
            dyn_ack_q  <= 1'b0;
            stat_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            gnt_dyn_q  <= gnt_dyn_d;
            last_dyn_q <= last_dyn_d;
            aborted_q  <= aborted_d;
            sel_q      <= sel_d;
            mosi_q     <= mosi_d;
            clk_en_q   <= clk_en_d;
            load_q     <= load_d;
            dyn_ack_q  <= dyn_ack_d;
            stat_ack_q <= stat_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.SEL      = sel_q;
    assign bus.MOSI     = mosi_q;
    assign bus.CLK_EN   = clk_en_q;
    assign bus.LOAD     = load_q;
    assign bus.DYN_ACK  = dyn_ack_q;
    assign bus.STAT_ACK = stat_ack_q;
    assign bus.BUSY     = busy_q;
    assign bus.ABORTED  = aborted_q;
endmodule
